// File: rtl/rssi_pkg.sv
// Shared constants, channel-width helper and the stage-1 to stage-2 payload
// for the multi-channel gain correction stage.
package rssi_pkg;

    localparam int DEF_MAX_DB         = 72;
    localparam int DEF_GAIN_STEP_LOG2 = 2;

    // Payload fields are sized for the widest supported instance (OUT_W <= 32)
    localparam int PAY_CH_W   = 8;
    localparam int PAY_CORR_W = 32;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    typedef struct packed {
        logic [PAY_CH_W-1:0]          ch;
        logic signed [PAY_CORR_W-1:0] corr;
        logic                         sat;
        logic                         seed;
    } s1_payload_t;

endpackage

// File: rtl/gain_correction_avg_if.sv
// Sample bus of the gain correction stage: detector samples in, RSSI samples out.
// valid_i / valid_o are single-cycle strobes; there is no ready, every sample is accepted.
interface gain_correction_avg_if
    import rssi_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SIG_W  = 8,
    parameter int GAIN_W = 6,
    parameter int OUT_W  = 16
);
    localparam int CH_W = ch_width(NUM_CH);

    logic                     valid_i;
    logic [CH_W-1:0]          ch_i;
    logic [SIG_W-1:0]         signal_dB_i;
    logic signed [GAIN_W-1:0] gain_dB_i;
    logic                     valid_o;
    logic [CH_W-1:0]          ch_o;
    logic signed [OUT_W-1:0]  rssi_dBFS_o;
    logic                     sat_o;

    modport slave (
        input  valid_i, ch_i, signal_dB_i, gain_dB_i,
        output valid_o, ch_o, rssi_dBFS_o, sat_o
    );

    modport master (
        output valid_i, ch_i, signal_dB_i, gain_dB_i,
        input  valid_o, ch_o, rssi_dBFS_o, sat_o
    );

endinterface

// File: rtl/rssi_ema.sv
// Single-channel exponential-average update: seeds or moves the fixed-point
// accumulator towards the new sample by 2^-EMA_SHIFT.
module rssi_ema #(
    parameter int OUT_W     = 16,
    parameter int EMA_SHIFT = 2
) (
    input  logic                          seed,
    input  logic signed [OUT_W-1:0]       corr,
    input  logic signed [OUT_W+EMA_SHIFT:0] acc,
    output logic signed [OUT_W+EMA_SHIFT:0] acc_new,
    output logic signed [OUT_W-1:0]       out
);
    localparam int AW = OUT_W + EMA_SHIFT + 1;

    logic signed [AW-1:0] target;

    always_comb begin
        target  = AW'(corr) <<< EMA_SHIFT;
        acc_new = seed ? target : acc + ((target - acc) >>> EMA_SHIFT);
        out     = OUT_W'(acc_new >>> EMA_SHIFT);
    end

endmodule

// File: rtl/gain_correction_avg.sv
// Multi-channel detector-to-dBFS correction with per-channel settling blanking
// and optional per-channel averaging (enabled by defining GAIN_CORR_AVG_EN).
module gain_correction_avg
    import rssi_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int SIG_W          = 8,
    parameter int GAIN_W         = 6,
    parameter int GAIN_STEP_LOG2 = DEF_GAIN_STEP_LOG2,
    parameter int MAX_DB         = DEF_MAX_DB,
    parameter int OUT_W          = 16,
    parameter int HOLDOFF        = 3,
    parameter int EMA_SHIFT      = 2
) (
    input logic clk,
    input logic rst_n,
    gain_correction_avg_if.slave bus
);
    localparam int CH_W  = ch_width(NUM_CH);
    localparam int CW    = max3(SIG_W, GAIN_W + GAIN_STEP_LOG2, 8) + 2;
    localparam int XW    = ((CW > OUT_W) ? CW : OUT_W) + 1;
    localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic signed [XW-1:0] OMAX = XW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [XW-1:0] OMIN = XW'(-(64'sd1 <<< (OUT_W - 1)));
    localparam logic [CH_W:0]        CH_LIMIT = (CH_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0]     HOLD_RELOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

    logic signed [GAIN_W-1:0] last_gain [NUM_CH];
    logic [CNT_W-1:0]         cnt [NUM_CH];
    logic [NUM_CH-1:0]        seen;
    logic [NUM_CH-1:0]        seed;

    logic signed [CW-1:0]    corr_full;
    logic signed [XW-1:0]    corr_x;
    logic signed [OUT_W-1:0] corr_clamp;
    logic                    sat;
    logic                    ch_ok;
    logic                    change;
    logic                    blank;
    logic                    seed_next;
    logic [CNT_W-1:0]        cur_cnt;
    logic [CNT_W-1:0]        cnt_next;

    s1_payload_t s1_q;
    logic        s1_valid;

    always_comb begin
        corr_full = $signed({{(CW - SIG_W){1'b0}}, bus.signal_dB_i})
                  - CW'(MAX_DB)
                  - (CW'(bus.gain_dB_i) <<< GAIN_STEP_LOG2);
        corr_x     = XW'(corr_full);
        corr_clamp = OUT_W'(corr_x);
        sat        = 1'b0;
        if (corr_x > OMAX) begin
            corr_clamp = OUT_W'(OMAX);
            sat        = 1'b1;
        end else if (corr_x < OMIN) begin
            corr_clamp = OUT_W'(OMIN);
            sat        = 1'b1;
        end
    end

    // A gain change reloads the blanking count; the changing sample is itself blanked.
    always_comb begin
        ch_ok   = {1'b0, bus.ch_i} < CH_LIMIT;
        cur_cnt = cnt[bus.ch_i];
        change  = seen[bus.ch_i] && (bus.gain_dB_i != last_gain[bus.ch_i]);
        if (change) begin
            blank     = (HOLDOFF > 0);
            cnt_next  = HOLD_RELOAD;
            seed_next = 1'b1;
        end else begin
            blank     = (cur_cnt != '0);
            cnt_next  = blank ? cur_cnt - CNT_W'(1) : '0;
            seed_next = seed[bus.ch_i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            seen     <= '0;
            seed     <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                last_gain[i] <= '0;
                cnt[i]       <= '0;
            end
        end else begin
            s1_valid <= 1'b0;
            if (bus.valid_i && ch_ok) begin
                last_gain[bus.ch_i] <= bus.gain_dB_i;
                seen[bus.ch_i]      <= 1'b1;
                cnt[bus.ch_i]       <= cnt_next;
                seed[bus.ch_i]      <= blank ? seed_next : 1'b0;
                if (!blank) begin
                    s1_valid    <= 1'b1;
                    s1_q.ch     <= PAY_CH_W'(bus.ch_i);
                    s1_q.corr   <= PAY_CORR_W'(corr_clamp);
                    s1_q.sat    <= sat;
                    s1_q.seed   <= seed_next;
                end
            end
        end
    end

    logic [CH_W-1:0]         s2_ch;
    logic signed [OUT_W-1:0] s2_corr;
    logic signed [OUT_W-1:0] s2_val;
    logic                    unused_pay;

    assign s2_ch      = s1_q.ch[CH_W-1:0];
    assign s2_corr    = s1_q.corr[OUT_W-1:0];
    assign unused_pay = ^s1_q;

`ifdef GAIN_CORR_AVG_EN
    localparam int AW = OUT_W + EMA_SHIFT + 1;

    logic signed [AW-1:0]    acc [NUM_CH];
    logic signed [AW-1:0]    acc_new;
    logic signed [OUT_W-1:0] ema_out;

    rssi_ema #(
        .OUT_W     (OUT_W),
        .EMA_SHIFT (EMA_SHIFT)
    ) u_ema (
        .seed    (s1_q.seed),
        .corr    (s2_corr),
        .acc     (acc[s2_ch]),
        .acc_new (acc_new),
        .out     (ema_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
        end else if (s1_valid) begin
            acc[s2_ch] <= acc_new;
        end
    end

    assign s2_val = ema_out;
`else
    assign s2_val = s2_corr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid_o     <= 1'b0;
            bus.ch_o        <= '0;
            bus.rssi_dBFS_o <= '0;
            bus.sat_o       <= 1'b0;
        end else begin
            bus.valid_o <= s1_valid;
            if (s1_valid) begin
                bus.ch_o        <= s2_ch;
                bus.rssi_dBFS_o <= s2_val;
                bus.sat_o       <= s1_q.sat;
            end
        end
    end

endmodule

// File: tb/tb_gain_correction_avg.sv
// Bench for gain_correction_avg: directed and random samples scored against a
// per-channel arithmetic model; a narrow OUT_W instance covers clamping.
module tb_gain_correction_avg;

    localparam int NUM_CH    = 4;
    localparam int SIG_W     = 8;
    localparam int GAIN_W    = 6;
    localparam int GSTEP     = 2;
    localparam int MAX_DB    = 72;
    localparam int OUT_W     = 16;
    localparam int HOLDOFF   = 3;
    localparam int EMA_SHIFT = 2;
    localparam int OMAXI     = (1 << (OUT_W - 1)) - 1;
    localparam int OMINI     = -(1 << (OUT_W - 1));

    typedef struct {
        int due;
        int ch;
        int rssi;
        int sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t exp_q[$];
    exp_t mon_e;

    int m_last [NUM_CH];
    int m_seen [NUM_CH];
    int m_rem  [NUM_CH];
    int m_seed [NUM_CH];
    int m_acc  [NUM_CH];
    int g_cur  [NUM_CH];

    gain_correction_avg_if #(.NUM_CH(NUM_CH), .SIG_W(SIG_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) bus ();
    gain_correction_avg_if #(.NUM_CH(NUM_CH), .SIG_W(SIG_W), .GAIN_W(GAIN_W), .OUT_W(6)) sbus ();

    gain_correction_avg #(
        .NUM_CH(NUM_CH), .SIG_W(SIG_W), .GAIN_W(GAIN_W), .GAIN_STEP_LOG2(GSTEP),
        .MAX_DB(MAX_DB), .OUT_W(OUT_W), .HOLDOFF(HOLDOFF), .EMA_SHIFT(EMA_SHIFT)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    gain_correction_avg #(
        .NUM_CH(NUM_CH), .SIG_W(SIG_W), .GAIN_W(GAIN_W), .GAIN_STEP_LOG2(GSTEP),
        .MAX_DB(MAX_DB), .OUT_W(6), .HOLDOFF(HOLDOFF), .EMA_SHIFT(EMA_SHIFT)
    ) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int fdiv(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q--;
        return q;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_last[i] = 0;
            m_seen[i] = 0;
            m_rem[i]  = 0;
            m_seed[i] = 1;
            m_acc[i]  = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_push(input int ch, input int sig, input int gain);
        int   corr;
        int   sat;
        int   w;
        exp_t e;
        w    = 1 << EMA_SHIFT;
        corr = sig - MAX_DB - gain * (1 << GSTEP);
        sat  = 0;
        if (corr > OMAXI) begin corr = OMAXI; sat = 1; end
        else if (corr < OMINI) begin corr = OMINI; sat = 1; end
        if (m_seen[ch] != 0 && gain != m_last[ch]) begin
            m_rem[ch]  = HOLDOFF;
            m_seed[ch] = 1;
        end
        m_seen[ch] = 1;
        m_last[ch] = gain;
        if (m_rem[ch] > 0) begin
            m_rem[ch]--;
            return;
        end
        e.due  = cyc + 2;
        e.ch   = ch;
        e.sat  = sat;
`ifdef GAIN_CORR_AVG_EN
        if (m_seed[ch] != 0) m_acc[ch] = corr * w;
        else m_acc[ch] = m_acc[ch] + fdiv(corr * w - m_acc[ch], w);
        m_seed[ch] = 0;
        e.rssi = fdiv(m_acc[ch], w);
`else
        e.rssi = corr;
`endif
        exp_q.push_back(e);
    endtask

    // Driver tasks
    task automatic drive(input int ch, input int sig, input int gain);
        @(posedge clk);
        #1;
        bus.valid_i     = 1'b1;
        bus.ch_i        = 2'(ch);
        bus.signal_dB_i = 8'(sig);
        bus.gain_dB_i   = 6'(gain);
        model_push(ch, sig, gain);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.valid_i  = 1'b0;
            sbus.valid_i = 1'b0;
        end
    endtask

    task automatic sdrive(input int ch, input int sig, input int gain);
        @(posedge clk);
        #1;
        bus.valid_i      = 1'b0;
        sbus.valid_i     = 1'b1;
        sbus.ch_i        = 2'(ch);
        sbus.signal_dB_i = 8'(sig);
        sbus.gain_dB_i   = 6'(gain);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.valid_i  = 1'b0;
        sbus.valid_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard: every cycle either the next expected sample is due or valid_o must be low
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            mon_e = exp_q.pop_front();
            chk("valid", 32'(bus.valid_o), 1);
            chk("ch", 32'(bus.ch_o), mon_e.ch);
            chk("rssi", 32'(bus.rssi_dBFS_o), mon_e.rssi);
            chk("sat", 32'(bus.sat_o), mon_e.sat);
        end else begin
            chk("idle_valid", 32'(bus.valid_o), 0);
        end
    end

    initial begin
        bus.valid_i      = 1'b0;
        bus.ch_i         = '0;
        bus.signal_dB_i  = '0;
        bus.gain_dB_i    = '0;
        sbus.valid_i     = 1'b0;
        sbus.ch_i        = '0;
        sbus.signal_dB_i = '0;
        sbus.gain_dB_i   = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ch", 32'(bus.ch_o), 0);
        chk("reset_rssi", 32'(bus.rssi_dBFS_o), 0);
        chk("reset_sat", 32'(bus.sat_o), 0);
        rst_n = 1'b1;

        // First sample is seeded, second is averaged
        drive(0, 100, 3);
        idle(3);
        chk("first_rssi", 32'(bus.rssi_dBFS_o), 16);
        chk("first_sat", 32'(bus.sat_o), 0);
        drive(0, 116, 3);
        idle(3);
`ifdef GAIN_CORR_AVG_EN
        chk("second_rssi", 32'(bus.rssi_dBFS_o), 20);
`else
        chk("second_rssi", 32'(bus.rssi_dBFS_o), 32);
`endif

        // Holdoff on ch1: three blanked, fourth seeded to 0
        drive(1, 90, 0);
        drive(1, 91, 0);
        for (int i = 0; i < 4; i++) drive(1, 80, 2);
        idle(3);
        chk("holdoff_rssi", 32'(bus.rssi_dBFS_o), 0);
        chk("holdoff_ch", 32'(bus.ch_o), 1);

        // Interleaved ch0/ch1/ch0 with differing gains
        for (int i = 0; i < 20; i++) begin
            drive(0, $urandom_range(0, 255), (i % 7 == 0) ? 5 : 3);
            drive(1, $urandom_range(0, 255), (i % 5 == 0) ? -4 : 2);
            drive(0, $urandom_range(0, 255), (i % 7 == 0) ? 5 : 3);
        end
        idle(4);

        // Narrow output instance clamps both ways
        sdrive(0, 0, 31);
        idle(3);
        chk("sat_low_rssi", 32'(sbus.rssi_dBFS_o), -32);
        chk("sat_low_flag", 32'(sbus.sat_o), 1);
        sdrive(1, 255, -32);
        idle(3);
        chk("sat_high_rssi", 32'(sbus.rssi_dBFS_o), 31);
        chk("sat_high_flag", 32'(sbus.sat_o), 1);

        // Reset with a sample in stage 1: nothing emitted, next sample seeded without holdoff
        drive(0, 200, 3);
        pulse_reset();
        idle(3);
        drive(0, 100, 5);
        idle(3);
        chk("post_reset_rssi", 32'(bus.rssi_dBFS_o), 8);
        chk("post_reset_ch", 32'(bus.ch_o), 0);

        // Random traffic with occasional gain changes and idle cycles
        for (int i = 0; i < NUM_CH; i++) g_cur[i] = int'($urandom_range(0, 63)) - 32;
        for (int i = 0; i < 400; i++) begin
            int ch;
            ch = int'($urandom_range(0, NUM_CH - 1));
            if ($urandom_range(0, 5) == 0) g_cur[ch] = int'($urandom_range(0, 63)) - 32;
            if ($urandom_range(0, 7) == 0) idle(1);
            drive(ch, $urandom_range(0, 255), g_cur[ch]);
        end
        idle(5);
        chk("drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
